// File: rtl/input_clk_meter_pkg.sv
// Shared types and default widths for the input clock meter.
// The state encoding is used by input_clk_meter; widths feed its parameter defaults.
package input_clk_meter_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } meter_state_t;

endpackage

// File: rtl/meas_edge_sync.sv
// Two-flop synchronizer plus a third flop for rising-edge detection of an async level.
// sync_out is the synchronized level; rise_pulse is a one-cycle pulse per rising edge.
module meas_edge_sync (
  input  logic clk,
  input  logic rstb,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse
);

  logic [2:0] sync_ff;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[1:0], async_in};
    end
  end

  assign sync_out   = sync_ff[1];
  assign rise_pulse = sync_ff[1] & ~sync_ff[2];

endmodule

// File: rtl/input_clk_meter.sv
// Counts rising edges of an async divided clock over a programmable reference-clock window.
// Optional duty-cycle high-time counter enabled by defining INPUT_CLK_METER_DUTY_EN.
module input_clk_meter
  import input_clk_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  input  logic             meas_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count,
  output logic             overflow
`ifdef INPUT_CLK_METER_DUTY_EN
  ,
  output logic [WIN_W-1:0] high_count
`endif
);

  meter_state_t     state;
  logic             start_q;
  logic             start_rise;
  logic [WIN_W-1:0] win_reg;
  logic [WIN_W-1:0] win_cnt;
  logic             meas_sync;
  logic             meas_rise;

  meas_edge_sync u_sync (
    .clk        (clk),
    .rstb       (rstb),
    .async_in   (meas_in),
    .sync_out   (meas_sync),
    .rise_pulse (meas_rise)
  );

  assign start_rise = start & ~start_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      win_reg    <= '0;
      win_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      edge_count <= '0;
      overflow   <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        IDLE, DONE: begin
          if (start_rise) begin
            win_reg    <= window_len;
            edge_count <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            state      <= ARM;
          end
        end
        ARM: begin
          if (win_reg == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            win_cnt <= win_reg;
            state   <= COUNT;
          end
        end
        COUNT: begin
          win_cnt <= win_cnt - 1'b1;
          // Saturate rather than wrap so an over-range input is flagged, not aliased.
          if (meas_rise) begin
            if (edge_count == '1) begin
              overflow <= 1'b1;
            end else begin
              edge_count <= edge_count + 1'b1;
            end
          end
          if (win_cnt == WIN_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef INPUT_CLK_METER_DUTY_EN
  // High-time count cannot exceed win_reg, so WIN_W bits never wrap.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      high_count <= '0;
    end else if ((state == IDLE || state == DONE) && start_rise) begin
      high_count <= '0;
    end else if (state == COUNT && meas_sync) begin
      high_count <= high_count + 1'b1;
    end
  end
`else
  logic unused_meas_sync;
  assign unused_meas_sync = meas_sync;
`endif

endmodule

// File: tb/tb_input_clk_meter.sv
// Directed + randomized self-checking bench for input_clk_meter (default and 4-bit counter builds).
`timescale 1ps/1ps
module tb_input_clk_meter;

  logic        clk;
  logic        rstb;
  logic        start;
  logic [15:0] window_len;
  logic        meas_in;
  logic        busy, done, overflow;
  logic [15:0] edge_count;
  logic        busy_s, done_s, overflow_s;
  logic [3:0]  edge_count_s;
`ifdef INPUT_CLK_METER_DUTY_EN
  logic [15:0] high_count;
  logic [15:0] high_count_s;
`endif

  int checks   = 0;
  int failures = 0;
  int hi_ps    = 4000;
  int lo_ps    = 4000;

  input_clk_meter #(.CNT_W(16), .WIN_W(16)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .start      (start),
    .window_len (window_len),
    .meas_in    (meas_in),
    .busy       (busy),
    .done       (done),
    .edge_count (edge_count),
    .overflow   (overflow)
`ifdef INPUT_CLK_METER_DUTY_EN
    ,
    .high_count (high_count)
`endif
  );

  input_clk_meter #(.CNT_W(4), .WIN_W(16)) dut_sat (
    .clk        (clk),
    .rstb       (rstb),
    .start      (start),
    .window_len (window_len),
    .meas_in    (meas_in),
    .busy       (busy_s),
    .done       (done_s),
    .edge_count (edge_count_s),
    .overflow   (overflow_s)
`ifdef INPUT_CLK_METER_DUTY_EN
    ,
    .high_count (high_count_s)
`endif
  );

  // 1 ns reference clock; posedges at 500 mod 1000 ps
  initial clk = 1'b0;
  always #500 clk = ~clk;

  // meas_in edges fall at 3 mod 10 ps, so they never coincide with a clk edge
  initial begin
    meas_in = 1'b0;
    #3;
    forever begin
      meas_in = 1'b1;
      #(hi_ps);
      meas_in = 1'b0;
      #(lo_ps);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert ((obs >= lo && obs <= hi) === 1'b1)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=[%0d..%0d]", tag, obs, lo, hi);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedge samples with busy high after start; bounded so a stuck DUT cannot hang.
  task automatic run_meas(input int w, output int n);
    window_len = 16'(w);
    pulse_start();
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Edge count expected within +-1 of window*Pclk/Pin (Pclk = 1000 ps)
  function automatic int exp_lo(input int w, input int p);
    int x;
    x = w * 1000 - p;
    return (x <= 0) ? 0 : (x + p - 1) / p;
  endfunction

  function automatic int exp_hi(input int w, input int p);
    return (w * 1000 + p) / p;
  endfunction

  initial begin
    int n, w, p, lo, hi;
    rstb       = 1'b0;
    start      = 1'b0;
    window_len = '0;

    #2700;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", edge_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_sat_count", edge_count_s, 0);
    @(negedge clk);
    rstb = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // Basic: 8 ns input period, 800-cycle window
    hi_ps = 4000; lo_ps = 4000;
    run_meas(800, n);
    chk("basic_busy_cycles", n, 801);
    chk("basic_done", done, 1);
    chk_range("basic_count", edge_count, 99, 101);
    chk("basic_ovf", overflow, 0);
    chk("sat_count", edge_count_s, 15);
    chk("sat_ovf", overflow_s, 1);

    // Zero window: ARM then straight to DONE
    window_len = '0;
    pulse_start();
    chk("zero_arm_busy", busy, 1);
    chk("zero_arm_done", done, 0);
    chk("sat_ovf_cleared", overflow_s, 0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_count", edge_count, 0);
    chk("zero_ovf", overflow, 0);

    // Randomized periods and windows against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      hi_ps = int'($urandom_range(150, 600)) * 10;
      lo_ps = int'($urandom_range(150, 600)) * 10;
      p = hi_ps + lo_ps;
      w = (i % 2 == 1) ? int'($urandom_range(100, 600)) : int'($urandom_range(5, 40));
      repeat (20) @(negedge clk);
      run_meas(w, n);
      lo = exp_lo(w, p);
      hi = exp_hi(w, p);
      chk("rand_busy_cycles", n, w + 1);
      chk("rand_done", done, 1);
      chk_range("rand_count", edge_count, lo, hi);
      chk("rand_ovf", overflow, 0);
      if (lo > 15) begin
        chk("rand_sat_count", edge_count_s, 15);
        chk("rand_sat_ovf", overflow_s, 1);
      end else if (hi < 15) begin
        chk_range("rand_sat_small_count", edge_count_s, lo, hi);
        chk("rand_sat_no_ovf", overflow_s, 0);
      end
    end

    // Extra starts during COUNT are ignored
    hi_ps = 2500; lo_ps = 2500;
    repeat (10) @(negedge clk);
    window_len = 16'd300;
    pulse_start();
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      n++;
      start = (n % 50 == 10);
      @(negedge clk);
    end
    start = 1'b0;
    chk("restart_ignored_busy_cycles", n, 301);
    chk_range("restart_ignored_count", edge_count, exp_lo(300, 5000), exp_hi(300, 5000));

    // Start in DONE restarts and drops done at once
    window_len = 16'd50;
    pulse_start();
    chk("done_restart_done", done, 0);
    chk("done_restart_busy", busy, 1);
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      n++;
      @(negedge clk);
    end
    chk("done_restart_len", n, 51);
    chk_range("done_restart_count", edge_count, exp_lo(50, 5000), exp_hi(50, 5000));

`ifdef INPUT_CLK_METER_DUTY_EN
    hi_ps = 2000; lo_ps = 6000;
    repeat (10) @(negedge clk);
    run_meas(800, n);
    chk_range("duty_high_count", high_count, 196, 204);
    chk_range("duty_edge_count", edge_count, 99, 101);
`endif

    // Asynchronous reset in the middle of COUNT
    hi_ps = 2000; lo_ps = 2000;
    window_len = 16'd500;
    pulse_start();
    repeat (200) @(negedge clk);
    chk("midrst_pre_busy", busy, 1);
    #200;
    rstb = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_count", edge_count, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_sat_ovf", overflow_s, 0);
    @(negedge clk);
    rstb = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_count", edge_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_clk_meter.md
Name: input_clk_meter

Overview:
- Measures the divided input clock produced by the input-divider stage (its gated measurement output).
- Counts rising edges of that asynchronous signal over a programmable window of reference-clock cycles, so firmware can read back the input frequency and check ndiv/bypass settings.
- Sits directly downstream of the divider's measurement output. Runs entirely in the reference clock domain. Results are read through the JTAG register bank.

Parameters:
- CNT_W, 16: width of the edge counter and of edge_count.
- WIN_W, 16: width of the window length and of the window counter.

Ports:
- clk  input  1  reference clock; all state is in this domain.
- rstb  input  1  asynchronous active-low reset.
- start  input  1  measurement request; only its 0->1 transition in clk is acted on.
- window_len  input  WIN_W  measurement window length in clk cycles; sampled on accepted start.
- meas_in  input  1  asynchronous divided clock from the divider's measurement output.
- busy  output  1  high in ARM or COUNT.
- done  output  1  high in DONE; result valid.
- edge_count  output  CNT_W  rising edges counted in the last window.
- overflow  output  1  edge counter saturated during the last window.

Behaviour:
- Reset is asynchronous and active-low (rstb). While rstb=0, all state clears: state=IDLE, busy=0, done=0, edge_count=0, overflow=0, synchronizer flops=0.
- Synchronizer:
  - meas_in passes through a 2-flop synchronizer, then a third flop for edge detect.
  - edge_pulse = sync & ~sync_d. Runs continuously, independent of state.
  - Sync-to-pulse latency is 2-3 clk cycles.
- start edge: start_rise = start & ~start_q, with start_q registered.
- States: IDLE, ARM, COUNT, DONE.
- IDLE:
  - On start_rise, latch window_len into win_reg, clear the edge counter and overflow, and go to ARM.
- ARM:
  - Lasts exactly one cycle.
  - If win_reg==0, go to DONE with edge_count=0.
  - Otherwise load the window counter with win_reg and go to COUNT.
- COUNT:
  - Each cycle, decrement the window counter and add edge_pulse to the edge counter.
  - The cycle in which the window counter goes 1->0 is counted.
  - Then go to DONE. COUNT lasts exactly win_reg cycles.
- DONE:
  - edge_count holds the result and done=1.
  - Holds until the next start_rise, which behaves as in IDLE (goes to ARM and deasserts done the same cycle).
- start_rise during ARM or COUNT is ignored; the measurement is not restarted.
- Saturation: the edge counter saturates at 2^CNT_W-1, and overflow is set and held until the next accepted start.
- Output timing: edge_count is the registered counter, and the value presented is final when done rises. done rises the cycle after the last COUNT cycle.
- Reset mid-measurement aborts immediately to IDLE with all outputs cleared.
- Expected result: with a steady input period P_in and reference period P_clk, edge_count ≈ win_reg*P_clk/P_in, ±1.

Optional Feature:
- Macro: INPUT_CLK_METER_DUTY_EN
- When defined:
  - Adds output high_count [WIN_W], reset 0.
  - Counts COUNT-state cycles in which the synchronized meas_in is 1.
  - Cleared on accepted start, frozen in DONE.
  - Gives the duty cycle as high_count/win_reg.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package input_clk_meter_pkg holds:
  - the state enum (IDLE, ARM, COUNT, DONE), 2 bits;
  - default width constants CNT_W_DEF=16 and WIN_W_DEF=16.
- One sub-module, meas_edge_sync: clk, rstb, async_in → sync_out, rise_pulse. It is the 3-flop synchronizer plus rising-edge detect. Reused for the duty-count level.

Test Plan:
- Reset check: assert rstb=0 mid-COUNT with meas_in toggling. Expect state IDLE and busy=done=edge_count=overflow=0 immediately (asynchronous). After release, idle until start.
- Basic count: clk period 1 ns, meas_in period 8 ns, window_len=800, pulse start. Expect busy for 801 cycles, then done=1 and edge_count in {99,100,101}.
- Zero window: window_len=0, pulse start. Expect done=1 two cycles after start_rise, edge_count=0, overflow=0.
- Saturation: CNT_W=4, meas_in period 3 ns, window_len=100. Expect edge_count=15 and overflow=1. A new start clears overflow.
- Start during COUNT: extra start pulses while busy=1 are ignored and the result matches a single-start run. A start in DONE restarts, deasserting done on the next cycle.
- Duty (INPUT_CLK_METER_DUTY_EN): meas_in 8 ns period, 25% high, window_len=800. Expect high_count in 200±4.
